// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use hazard unit for an in-order pipeline.
// Optional stall_cycles perf counter enabled by defining FWD_HAZARD_PERF_CNT_EN.
module fwd_hazard_unit #(
    parameter int REG_AW     = 5,
    parameter int NUM_STAGES = 3,
    parameter int LOAD_LAT   = 1,
    localparam int FW        = $clog2(NUM_STAGES + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              flush,
    output logic              stall,
    output logic [FW-1:0]     fwd_rs,
    output logic [FW-1:0]     fwd_rt
`ifdef FWD_HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cycles
`endif
);

    localparam logic [FW-1:0] LOAD_LAT_K = FW'(LOAD_LAT);

    logic [REG_AW-1:0] trk_rd [1:NUM_STAGES];
    logic              trk_we [1:NUM_STAGES];
    logic              trk_ld [1:NUM_STAGES];

    logic          rs_hit, rt_hit;
    logic          rs_ld, rt_ld;
    logic [FW-1:0] rs_k, rt_k;
    logic          rs_load_use, rt_load_use;
    logic          issue;

    // Scan from the oldest comparable stage down so the youngest match overwrites.
    // The last stage is skipped: the register file already returns its result.
    always_comb begin
        rs_hit = 1'b0;
        rs_k   = '0;
        rs_ld  = 1'b0;
        rt_hit = 1'b0;
        rt_k   = '0;
        rt_ld  = 1'b0;
        for (int k = NUM_STAGES - 1; k >= 1; k--) begin
            if (trk_we[k] && (trk_rd[k] != '0) && (trk_rd[k] == id_rs)) begin
                rs_hit = 1'b1;
                rs_k   = FW'(k);
                rs_ld  = trk_ld[k];
            end
            if (trk_we[k] && (trk_rd[k] != '0) && (trk_rd[k] == id_rt)) begin
                rt_hit = 1'b1;
                rt_k   = FW'(k);
                rt_ld  = trk_ld[k];
            end
        end
    end

    assign rs_load_use = rs_hit && rs_ld && (rs_k <= LOAD_LAT_K);
    assign rt_load_use = rt_hit && rt_ld && (rt_k <= LOAD_LAT_K);
    assign stall       = id_valid && !flush && (rs_load_use || rt_load_use);
    assign issue       = id_valid && !stall && !flush;

    // Select is k+1 because the producer advances one stage as the consumer enters EX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= NUM_STAGES; k++) begin
                trk_rd[k] <= '0;
                trk_we[k] <= 1'b0;
                trk_ld[k] <= 1'b0;
            end
            fwd_rs <= '0;
            fwd_rt <= '0;
        end else begin
            if (issue) begin
                trk_rd[1] <= id_rd;
                trk_we[1] <= id_regwrite;
                trk_ld[1] <= id_memread;
            end else begin
                trk_rd[1] <= '0;
                trk_we[1] <= 1'b0;
                trk_ld[1] <= 1'b0;
            end
            for (int k = 2; k <= NUM_STAGES; k++) begin
                trk_rd[k] <= trk_rd[k-1];
                trk_we[k] <= trk_we[k-1];
                trk_ld[k] <= trk_ld[k-1];
            end
            fwd_rs <= (issue && rs_hit) ? rs_k + FW'(1) : '0;
            fwd_rt <= (issue && rt_hit) ? rt_k + FW'(1) : '0;
        end
    end

`ifdef FWD_HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit (NUM_STAGES=3, LOAD_LAT=1): vector table,
// scoreboard queue for registered selects, and a reset-during-stall sequence.
module tb_fwd_hazard_unit;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       id_regwrite, id_memread, flush;
    logic       stall;
    logic [1:0] fwd_rs, fwd_rt;
`ifdef FWD_HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles;
`endif

    int checks = 0;
    int fails  = 0;
    int exp_stall_count = 0;

    typedef struct {
        logic       valid;
        logic [4:0] rs, rt, rd;
        logic       rw, mr, fl;
        logic       exp_stall;
        logic [1:0] exp_rs, exp_rt;
    } vec_t;

    typedef struct {
        logic [1:0] rs;
        logic [1:0] rt;
        string      tag;
    } exp_t;

    vec_t vecs[17];
    exp_t sb[$];

    fwd_hazard_unit #(.REG_AW(5), .NUM_STAGES(3), .LOAD_LAT(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_rd       (id_rd),
        .id_regwrite (id_regwrite),
        .id_memread  (id_memread),
        .flush       (flush),
        .stall       (stall),
        .fwd_rs      (fwd_rs),
        .fwd_rt      (fwd_rt)
`ifdef FWD_HAZARD_PERF_CNT_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic v, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                logic rw, logic mr, logic fl, logic st,
                                logic [1:0] ers, logic [1:0] ert);
        vec_t r;
        r.valid = v;  r.rs = rs;  r.rt = rt;  r.rd = rd;
        r.rw = rw;    r.mr = mr;  r.fl = fl;
        r.exp_stall = st;  r.exp_rs = ers;  r.exp_rt = ert;
        return r;
    endfunction

    task automatic applyStimulus(input vec_t v);
        id_valid    = v.valid;
        id_rs       = v.rs;
        id_rt       = v.rt;
        id_rd       = v.rd;
        id_regwrite = v.rw;
        id_memread  = v.mr;
        flush       = v.fl;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called one time unit after a rising edge: compares registered selects to the queue head.
    task automatic popAndCompare();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
        end else begin
            e = sb.pop_front();
            checkOutput({e.tag, " fwd_rs"}, 32'(fwd_rs), 32'(e.rs));
            checkOutput({e.tag, " fwd_rt"}, 32'(fwd_rt), 32'(e.rt));
        end
    endtask

    task automatic pushExp(input logic [1:0] rs, input logic [1:0] rt, input string tag);
        exp_t e;
        e.rs = rs;  e.rt = rt;  e.tag = tag;
        sb.push_back(e);
    endtask

    initial begin
        //            v  rs  rt  rd rw mr fl st rs rt
        vecs[0]  = mk(1,  1,  2,  3, 1, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1,  3,  0,  6, 1, 0, 0, 0, 2, 0);
        vecs[2]  = mk(0,  0,  0,  0, 0, 0, 0, 0, 0, 0);
        vecs[3]  = mk(1,  6,  6,  0, 1, 0, 0, 0, 3, 3);
        vecs[4]  = mk(1,  0,  0,  5, 1, 1, 0, 0, 0, 0);
        vecs[5]  = mk(1,  5,  7,  8, 1, 0, 0, 1, 0, 0);
        vecs[6]  = mk(1,  5,  7,  8, 1, 0, 0, 0, 3, 0);
        vecs[7]  = mk(1,  4,  4,  4, 1, 0, 0, 0, 0, 0);
        vecs[8]  = mk(1,  4,  8,  4, 1, 0, 0, 0, 2, 3);
        vecs[9]  = mk(1,  4,  4,  9, 1, 1, 0, 0, 2, 2);
        vecs[10] = mk(1,  9,  9, 10, 1, 0, 1, 0, 0, 0);
        vecs[11] = mk(1,  9,  1,  2, 0, 0, 0, 0, 3, 0);
        vecs[12] = mk(1,  2,  9, 11, 1, 1, 0, 0, 0, 0);
        vecs[13] = mk(1,  1, 11, 12, 1, 1, 0, 1, 0, 0);
        vecs[14] = mk(1,  1, 11, 12, 1, 1, 0, 0, 0, 3);
        vecs[15] = mk(0, 12,  0,  0, 0, 0, 0, 0, 0, 0);
        vecs[16] = mk(1, 12, 12,  0, 0, 0, 0, 0, 3, 3);

        rst_n = 1'b0;
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #2;
        checkOutput("reset stall", 32'(stall), 32'd0);
        checkOutput("reset fwd_rs", 32'(fwd_rs), 32'd0);
        checkOutput("reset fwd_rt", 32'(fwd_rt), 32'd0);
`ifdef FWD_HAZARD_PERF_CNT_EN
        checkOutput("reset stall_cycles", stall_cycles, 32'd0);
`endif
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i]);
            #4;
            checkOutput($sformatf("v%0d stall", i), 32'(stall), 32'(vecs[i].exp_stall));
            if (vecs[i].exp_stall) exp_stall_count++;
            pushExp(vecs[i].exp_rs, vecs[i].exp_rt, $sformatf("v%0d", i));
            @(posedge clk);
            #1;
            popAndCompare();
        end
`ifdef FWD_HAZARD_PERF_CNT_EN
        checkOutput("table stall_cycles", stall_cycles, 32'(exp_stall_count));
`endif

        // Reset asserted in the middle of a load-use stall.
        applyStimulus(mk(1, 0, 0, 7, 1, 0, 0, 0, 0, 0));
        pushExp(2'd0, 2'd0, "rst-seq issue rd7");
        @(posedge clk);
        #1;
        popAndCompare();
        applyStimulus(mk(1, 7, 0, 5, 1, 1, 0, 0, 0, 0));
        #4;
        checkOutput("rst-seq load stall", 32'(stall), 32'd0);
        pushExp(2'd2, 2'd0, "rst-seq load");
        @(posedge clk);
        #1;
        popAndCompare();
        applyStimulus(mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 0));
        #3;
        checkOutput("rst-seq pre stall", 32'(stall), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst-seq async stall", 32'(stall), 32'd0);
        checkOutput("rst-seq async fwd_rs", 32'(fwd_rs), 32'd0);
        checkOutput("rst-seq async fwd_rt", 32'(fwd_rt), 32'd0);
`ifdef FWD_HAZARD_PERF_CNT_EN
        checkOutput("rst-seq stall_cycles", stall_cycles, 32'd0);
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;
        #3;
        checkOutput("rst-seq post stall", 32'(stall), 32'd0);
        pushExp(2'd0, 2'd0, "rst-seq post issue");
        @(posedge clk);
        #1;
        popAndCompare();

        if (sb.size() != 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL scoreboard drain: got %0d entries, expected 0", sb.size());
        end

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
